// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial sequence detectors.
// Provides the detector state encoding, a low-bit mask builder and the
// pattern-length clamp used when a new configuration is loaded.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } seq_state_e;

  // Widest pattern the helpers below can describe; callers narrow the
  // returned mask to their own PAT_W with a width cast.
  localparam int SEQ_MAX_W = 64;

  // Mask with the low 'len' bits set.
  function automatic logic [SEQ_MAX_W-1:0] len_mask(input int len);
    logic [SEQ_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < SEQ_MAX_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

  // A zero length is meaningless, so it behaves as a single-bit pattern;
  // anything longer than the history register is cut to the register width.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with a synchronous clear that beats increment.
// Ports: clk/rst_n, clr_i (clear), inc_i (count one), cnt_o (current value).
// Holds at all-ones once reached until cleared or reset.
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector (1..PAT_W bits, overlap/non-overlap,
// registered or same-cycle match, saturating match counter).
// Ports: en/din/din_valid stream in, overlap + cfg_* configuration,
// cnt_clr counter clear; match pulse, match_cnt and state out.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 8,
  parameter int               MEALY       = 0,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(8'b0000_1011),
  parameter int               DEF_LEN     = 4,
  localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  localparam logic [LEN_W-1:0] DEF_LEN_C = LEN_W'(clamp_len(DEF_LEN, PAT_W));

  seq_state_e       state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d, hist_next;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_next;
  logic [LEN_W-1:0] len_q, len_d;
  logic             match_q;
  logic             accept;
  logic             hit;

  // Speculative view of history/fill as if the current bit were taken.
  // Fill saturates at len so overlapping matches can fire on every bit.
  always_comb begin
    accept    = en && din_valid;
    hist_next = accept ? {hist_q[PAT_W-2:0], din} : hist_q;
    if (!accept) begin
      fill_next = fill_q;
    end else if (fill_q >= len_q) begin
      fill_next = len_q;
    end else begin
      fill_next = fill_q + LEN_W'(1);
    end
    mask = PAT_W'(len_mask(int'(len_q)));
    // A config load restarts the search, so the bit arriving with it never counts.
    hit  = accept && !cfg_load && (fill_next >= len_q) &&
           (((hist_next ^ pat_q) & mask) == '0);
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;

    // Configuration is latched even while disabled.
    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
    end

    if (!en) begin
      state_d = ST_IDLE;
      fill_d  = '0;
    end else if (cfg_load) begin
      state_d = ST_FILL;
      fill_d  = '0;
    end else begin
      hist_d = hist_next;
      if (hit && !overlap) begin
        // Non-overlapping: the matched bits are consumed.
        state_d = ST_FILL;
        fill_d  = '0;
      end else begin
        fill_d  = fill_next;
        state_d = (fill_next == len_q) ? ST_ARMED : ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= DEF_LEN_C;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      match_q <= hit;
    end
  end

  seq_det_sat_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (hit),
    .cnt_o (match_cnt)
  );

  assign match = (MEALY != 0) ? hit : match_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: one registered-match instance (CNT_W=2) and
// one same-cycle-match instance (CNT_W=8) share all stimulus.
// Expected hits are queued per driven bit and popped one cycle later for the
// registered instance; the same-cycle instance is compared immediately.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, din, din_valid, overlap, cfg_load, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic       m_match, y_match;
  logic [1:0] m_cnt;
  logic [7:0] y_cnt;
  logic [1:0] m_state, y_state;

  int n_chk  = 0;
  int n_pass = 0;

  logic exp_q[$];
  logic cur_en = 1'b0;
  logic cur_ov = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .PAT_W (8), .CNT_W (2), .MEALY (0)
  ) u_moore (
    .clk (clk), .rst_n (rst_n), .en (en), .din (din), .din_valid (din_valid),
    .overlap (overlap), .cfg_load (cfg_load), .cfg_pattern (cfg_pattern),
    .cfg_len (cfg_len), .cnt_clr (cnt_clr),
    .match (m_match), .match_cnt (m_cnt), .state (m_state)
  );

  seq_pattern_detector #(
    .PAT_W (8), .CNT_W (8), .MEALY (1)
  ) u_mealy (
    .clk (clk), .rst_n (rst_n), .en (en), .din (din), .din_valid (din_valid),
    .overlap (overlap), .cfg_load (cfg_load), .cfg_pattern (cfg_pattern),
    .cfg_len (cfg_len), .cnt_clr (cnt_clr),
    .match (y_match), .match_cnt (y_cnt), .state (y_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then compare both match outputs.
  task automatic drive(input logic v, input logic d, input logic ld, input logic clr,
                       input logic [7:0] pat, input logic [3:0] len, input logic exp_hit);
    logic exp_m;
    @(negedge clk);
    en          = cur_en;
    overlap     = cur_ov;
    din_valid   = v;
    din         = d;
    cfg_load    = ld;
    cnt_clr     = clr;
    cfg_pattern = pat;
    cfg_len     = len;
    #1;
    exp_m = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    chk("moore_match", 32'(m_match), 32'(exp_m));
    chk("mealy_match", 32'(y_match), 32'(exp_hit));
    exp_q.push_back(exp_hit);
  endtask

  task automatic bit_(input logic v, input logic d, input logic exp_hit);
    drive(v, d, 1'b0, 1'b0, 8'h00, 4'd0, exp_hit);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len,
                      input logic v, input logic d, input logic clr);
    drive(v, d, 1'b1, clr, pat, len, 1'b0);
  endtask

  task automatic bits(input int n, input logic [15:0] d, input logic [15:0] e);
    // d/e hold the stream MSB-first over n bits.
    for (int i = n - 1; i >= 0; i--) begin
      bit_(1'b1, d[i], e[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0; overlap = 1'b0;
    cfg_load = 1'b0; cnt_clr = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_match", 32'(m_match), 32'd0);
    chk("rst_cnt",   32'(m_cnt),   32'd0);
    chk("rst_state", 32'(m_state), 32'd0);
    chk("rst_ycnt",  32'(y_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Overlapping, default pattern 1011 len 4.
    cur_en = 1'b1; cur_ov = 1'b1;
    bits(7, 16'b1011011, 16'b0001001);
    bit_(1'b0, 1'b0, 1'b0);
    chk("ovl_cnt",   32'(m_cnt),   32'd2);
    chk("ovl_ycnt",  32'(y_cnt),   32'd2);
    chk("ovl_state", 32'(m_state), 32'd2);

    // Non-overlapping: fill restarts after the hit.
    cur_ov = 1'b0;
    load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b1);
    bits(4, 16'b1011, 16'b0001);
    bit_(1'b0, 1'b0, 1'b0);
    chk("novl_state_hit", 32'(m_state), 32'd1);
    bits(3, 16'b011, 16'b000);
    bit_(1'b0, 1'b0, 1'b0);
    chk("novl_state_b7", 32'(m_state), 32'd1);
    bits(1, 16'b0, 16'b0);
    bit_(1'b0, 1'b0, 1'b0);
    chk("novl_state_b8", 32'(m_state), 32'd2);
    chk("novl_cnt",      32'(m_cnt),   32'd1);

    // Same-cycle match with valid gaps (din high but not qualified).
    cur_ov = 1'b1;
    load(8'h03, 4'd2, 1'b0, 1'b0, 1'b1);
    bit_(1'b1, 1'b1, 1'b0);
    repeat (3) bit_(1'b0, 1'b1, 1'b0);
    bit_(1'b1, 1'b1, 1'b1);
    bit_(1'b0, 1'b0, 1'b0);
    chk("gap_cnt",  32'(m_cnt), 32'd1);
    chk("gap_ycnt", 32'(y_cnt), 32'd1);

    // Saturation, then clear colliding with a hit.
    load(8'h01, 4'd1, 1'b0, 1'b0, 1'b1);
    bits(6, 16'b111111, 16'b111111);
    bit_(1'b0, 1'b0, 1'b0);
    chk("sat_cnt",  32'(m_cnt), 32'd3);
    chk("sat_ycnt", 32'(y_cnt), 32'd6);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b1);
    bit_(1'b0, 1'b0, 1'b0);
    chk("clr_cnt",  32'(m_cnt), 32'd0);
    chk("clr_ycnt", 32'(y_cnt), 32'd0);

    // Load mid-stream: earlier bits and the bit arriving with the load are ignored.
    bits(2, 16'b11, 16'b11);
    load(8'h06, 4'd3, 1'b1, 1'b0, 1'b0);
    bits(3, 16'b110, 16'b001);

    // Length 0 behaves as 1.
    load(8'h01, 4'd0, 1'b0, 1'b0, 1'b0);
    bits(3, 16'b011, 16'b011);

    // Length 12 clamps to 8.
    load(8'hA5, 4'd12, 1'b0, 1'b0, 1'b0);
    bits(8, 16'b10100101, 16'b00000001);

    // Reset with a registered match in flight.
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0;
    #1;
    chk("rst_mid_match", 32'(m_match), 32'd0);
    chk("rst_mid_state", 32'(m_state), 32'd0);
    chk("rst_mid_ystate", 32'(y_state), 32'd0);
    chk("rst_mid_cnt",   32'(m_cnt),   32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern restored by reset.
    bits(4, 16'b1011, 16'b0001);
    bit_(1'b0, 1'b0, 1'b0);
    chk("def_state", 32'(m_state), 32'd2);

    // One disabled cycle clears fill; a stale fill would hit on the 3rd bit.
    cur_en = 1'b0;
    bit_(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("dis_state", 32'(m_state), 32'd0);
    cur_en = 1'b1;
    bits(6, 16'b011011, 16'b000001);
    bit_(1'b0, 1'b0, 1'b0);
    chk("end_cnt",  32'(m_cnt), 32'd2);
    chk("end_ycnt", 32'(y_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
